// File: rtl/xbar_pkg.sv
// Shared types and helpers for the cross-bar round-robin arbiter slice.
package xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // rr_pick works on a fixed-width request vector; callers zero-extend.
  localparam int RR_MAX_PORTS = 32;
  localparam int RR_IDX_W     = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // First requester searching upward from last+1 with wrap; returns last if none.
  function automatic int rr_pick(input logic [RR_MAX_PORTS-1:0] req_vec,
                                 input int last, input int num);
    int idx;
    int pick;
    pick = last;
    for (int off = RR_MAX_PORTS; off >= 1; off--) begin
      if (off <= num) begin
        idx = last + off;
        if (idx >= num) idx = idx - num;
        if (req_vec[idx[RR_IDX_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter_if.sv
// Cross-bar req/ack/resp port bundle; PORTS lanes share one broadcast rdata.
interface xbar_rr_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int PORTS  = 1
);
  import xbar_pkg::*;

  logic [PORTS-1:0]             req;
  logic [PORTS-1:0][AWIDTH-1:0] addr;
  logic [PORTS-1:0]             cmd;
  logic [PORTS-1:0][DWIDTH-1:0] wdata;
  logic [PORTS-1:0]             ack;
  logic [DWIDTH-1:0]            rdata;
  logic [PORTS-1:0]             resp;

  modport master (output req, addr, cmd, wdata, input  ack, rdata, resp);
  modport slave  (input  req, addr, cmd, wdata, output ack, rdata, resp);

endinterface

// File: rtl/xbar_id_fifo.sv
// In-order FIFO of initiator IDs for reads awaiting a response.
module xbar_id_fifo
  import xbar_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter sharing one cross-bar target among MASTER_NUM initiators,
// with in-order routing of read responses back to their originators.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MASTER_NUM  = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic               aclk,
  input  logic               areset,
  xbar_rr_arbiter_if.slave   s,
  xbar_rr_arbiter_if.master  m,
  output logic               err_resp
);

  localparam int GW = $clog2(MASTER_NUM);

  arb_state_t                  state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [GW-1:0]               last_q, last_d;
  logic [RR_MAX_PORTS-1:0]     req_ext;
  logic                        xfer_done;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [GW-1:0]               fifo_dout;

  assign xfer_done = (state_q == BUSY) && m.req[0] && m.ack[0];
  assign fifo_push = xfer_done && (m.cmd[0] == CMD_READ);
  assign fifo_pop  = m.resp[0] && !fifo_empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(MASTER_NUM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    req_ext = '0;
    req_ext[MASTER_NUM-1:0] = s.req;
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // A full ID FIFO stalls writes too, keeping arbitration order simple.
        if ((|s.req) && !fifo_full) begin
          state_d = BUSY;
          grant_d = GW'(rr_pick(req_ext, int'(last_q), MASTER_NUM));
        end
      end
      BUSY: begin
        if (xfer_done) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m.req   = '0;
    m.addr  = '0;
    m.cmd   = '0;
    m.wdata = '0;
    s.ack   = '0;
    if (state_q == BUSY) begin
      m.req[0]      = s.req[grant_q];
      m.addr[0]     = s.addr[grant_q];
      m.cmd[0]      = s.cmd[grant_q];
      m.wdata[0]    = s.wdata[grant_q];
      s.ack[grant_q] = m.ack[0];
    end
  end

  always_comb begin
    s.resp = '0;
    if (fifo_pop) s.resp[fifo_dout] = 1'b1;
  end

  assign s.rdata = m.rdata;

  always_ff @(posedge aclk) begin
    if (areset)                        err_resp <= 1'b0;
    else if (m.resp[0] && fifo_empty)  err_resp <= 1'b1;
  end

  xbar_id_fifo #(
    .WIDTH (GW),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (grant_q),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
